// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction-fetch and data SRAM-like ports onto one AXI master.
// One read (data has priority) and one data write may be outstanding at a time.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t    r_state, r_state_nxt;
    w_state_t    w_state, w_state_nxt;
    logic        live_q;
    logic        rd_owner_q;
    logic [31:0] rd_addr_q;
    logic [2:0]  rd_size_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic [2:0]  wr_size_q;
    logic [3:0]  wr_strb_q;
    logic        aw_done_q, w_done_q, aw_done_nxt, w_done_nxt;
    logic        data_rd_acc, data_wr_acc, inst_acc, data_rd_busy;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic        unused_rid;

    // Acceptance; live_q keeps both ports closed in the first cycle after reset.
    always_comb begin
        data_rd_busy = (r_state != R_IDLE) && rd_owner_q;
        data_rd_acc  = live_q && resetn && data_sram_req && !data_sram_wr
                       && (r_state == R_IDLE) && (w_state == W_IDLE);
        data_wr_acc  = live_q && resetn && data_sram_req && data_sram_wr
                       && (w_state == W_IDLE) && !data_rd_busy;
        inst_acc     = live_q && resetn && inst_sram_req
                       && (r_state == R_IDLE) && !data_rd_acc;
    end

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready && resetn;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready && resetn;

    assign inst_sram_addr_ok = inst_acc;
    assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_sram_data_ok = r_hs && !rid[0];
    assign data_sram_data_ok = (r_hs && rid[0]) || b_hs;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;
    assign unused_rid        = ^rid[3:1];

    assign arid    = {3'b000, rd_owner_q};
    assign araddr  = rd_addr_q;
    assign arsize  = rd_size_q;
    assign arvalid = (r_state == R_AR);
    assign rready  = (r_state == R_WAIT);
    assign awaddr  = wr_addr_q;
    assign awsize  = wr_size_q;
    assign wdata   = wr_data_q;
    assign wstrb   = wr_strb_q;
    assign awvalid = (w_state == W_REQ) && !aw_done_q;
    assign wvalid  = (w_state == W_REQ) && !w_done_q;
    assign bready  = (w_state == W_B);

    // Next-state logic for both channel FSMs.
    always_comb begin
        r_state_nxt = r_state;
        w_state_nxt = w_state;
        aw_done_nxt = aw_done_q;
        w_done_nxt  = w_done_q;
        case (r_state)
            R_IDLE:  if (data_rd_acc || inst_acc) r_state_nxt = R_AR;
            R_AR:    if (ar_hs) r_state_nxt = R_WAIT;
            R_WAIT:  if (r_hs) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
        case (w_state)
            W_IDLE: begin
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                if (data_wr_acc) w_state_nxt = W_REQ;
            end
            W_REQ: begin
                aw_done_nxt = aw_done_q || aw_hs;
                w_done_nxt  = w_done_q || w_hs;
                if (aw_done_nxt && w_done_nxt) w_state_nxt = W_B;
            end
            W_B:     if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // State and request-capture registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= R_IDLE;
            w_state    <= W_IDLE;
            live_q     <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_size_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_size_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            r_state   <= r_state_nxt;
            w_state   <= w_state_nxt;
            live_q    <= 1'b1;
            aw_done_q <= aw_done_nxt;
            w_done_q  <= w_done_nxt;
            if (data_rd_acc) begin
                rd_owner_q <= 1'b1;
                rd_addr_q  <= data_sram_addr;
                rd_size_q  <= {1'b0, data_sram_size};
            end else if (inst_acc) begin
                rd_owner_q <= 1'b0;
                rd_addr_q  <= inst_sram_addr;
                rd_size_q  <= 3'd2;
            end
            if (data_wr_acc) begin
                wr_addr_q <= data_sram_addr;
                wr_data_q <= data_sram_wdata;
                wr_size_q <= {1'b0, data_sram_size};
                wr_strb_q <= data_sram_wstrb;
            end
        end
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed scenarios followed by a randomized run against a memory-level reference model
// and an in-bench AXI slave.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_addr, inst_sram_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  arid, rid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;

    int vectors = 0;
    int miscompares = 0;

    // Reference model and slave state for the randomized phase
    logic [31:0] refmem [16];
    logic [31:0] smem [16];
    logic [31:0] iq [$];
    logic [31:0] dq [$];
    bit          dq_rd [$];
    int          rd_out, wr_out, data_rd_out, r_dly, b_dly;
    bit          inst_hold, data_hold, ar_got, aw_got, w_got, b_armed, gen;
    logic [31:0] s_araddr, s_awaddr, s_wdata, exp_ar_addr, exp_aw_addr, exp_wdata;
    logic [3:0]  s_arid, s_wstrb, exp_arid, exp_wstrb;
    logic [2:0]  exp_arsize, exp_awsize;
    logic        e_inst_ok, e_data_ok, e_r_hs, e_b_hs;
    logic [31:0] popped;
    bit          popped_rd;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({arvalid, rready, awvalid, wvalid, bready, inst_sram_addr_ok,
                      data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}), 32'd0);
    endtask

    task automatic clear_inputs();
        inst_sram_req = 0; inst_sram_addr = '0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = '0; data_sram_wstrb = '0;
        data_sram_addr = '0; data_sram_wdata = '0;
        arready = 0; rid = '0; rdata = '0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
    endtask

    task automatic data_write(input logic [31:0] a, input logic [1:0] sz,
                              input logic [3:0] st, input logic [31:0] d);
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = a;
        data_sram_size = sz; data_sram_wstrb = st; data_sram_wdata = d;
    endtask

    function automatic logic [31:0] ifun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    initial begin
        clear_inputs();
        // Reset with requests pending: nothing may be accepted
        resetn = 0; inst_sram_req = 1; data_sram_req = 1;
        repeat (3) tick();
        look();
        chk_quiet("reset_outputs");
        chk("reset_araddr", araddr, 32'd0);
        chk("reset_awaddr", awaddr, 32'd0);
        chk("reset_wdata", wdata, 32'd0);
        chk("reset_sizes_strb", 32'({arsize, awsize, wstrb}), 32'd0);
        tick(); resetn = 1; look();
        chk_quiet("post_reset_first_cycle");
        tick(); inst_sram_req = 0; data_sram_req = 0; look();
        chk_quiet("post_reset_idle");

        // A: instruction read
        tick(); inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; look();
        chk("A_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("A_data_addr_ok", data_sram_addr_ok, 0);
        tick(); inst_sram_req = 0; arready = 1; look();
        chk("A_arvalid", arvalid, 1);
        chk("A_arid", arid, 0);
        chk("A_araddr", araddr, 32'h1c00_0000);
        chk("A_arsize", arsize, 2);
        tick(); arready = 0; look();
        chk("A_rready", rready, 1);
        chk("A_arvalid_low", arvalid, 0);
        chk("A_no_early_ok", inst_sram_data_ok, 0);
        tick(); look();
        chk("A_wait_ok", inst_sram_data_ok, 0);
        tick(); rvalid = 1; rid = 0; rdata = 32'h0280_0c0c; look();
        chk("A_inst_data_ok", inst_sram_data_ok, 1);
        chk("A_inst_rdata", inst_sram_rdata, 32'h0280_0c0c);
        chk("A_data_ok_other", data_sram_data_ok, 0);
        tick(); rvalid = 0; look();
        chk("A_rready_done", rready, 0);
        chk("A_single_ok", inst_sram_data_ok, 0);

        // B: simultaneous inst and data reads, data first
        tick();
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0040;
        data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 32'h8000_0010;
        look();
        chk("B_data_addr_ok", data_sram_addr_ok, 1);
        chk("B_inst_stalled", inst_sram_addr_ok, 0);
        tick(); data_sram_req = 0; arready = 1; look();
        chk("B_arid_data", arid, 1);
        chk("B_araddr_data", araddr, 32'h8000_0010);
        chk("B_inst_stall_ar", inst_sram_addr_ok, 0);
        tick(); arready = 0; rvalid = 1; rid = 4'h1; rdata = 32'hdead_beef; look();
        chk("B_data_data_ok", data_sram_data_ok, 1);
        chk("B_data_rdata", data_sram_rdata, 32'hdead_beef);
        chk("B_inst_no_ok", inst_sram_data_ok, 0);
        chk("B_inst_stall_r", inst_sram_addr_ok, 0);
        tick(); rvalid = 0; look();
        chk("B_inst_accept_after", inst_sram_addr_ok, 1);
        tick(); inst_sram_req = 0; arready = 1; look();
        chk("B_arid_inst", arid, 0);
        chk("B_araddr_inst", araddr, 32'h1c00_0040);
        tick(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h1234_5678; look();
        chk("B_inst_data_ok", inst_sram_data_ok, 1);
        tick(); rvalid = 0; look();

        // C: byte write, AW ready at +1, W ready at +3
        tick(); data_write(32'h3, 2'd0, 4'b1000, 32'hAB00_0000); look();
        chk("C_addr_ok", data_sram_addr_ok, 1);
        tick(); data_sram_req = 0; awready = 1; look();
        chk("C_awvalid", awvalid, 1);
        chk("C_wvalid", wvalid, 1);
        chk("C_awsize", awsize, 0);
        chk("C_awaddr", awaddr, 32'h3);
        chk("C_wstrb", wstrb, 4'b1000);
        tick(); awready = 0; look();
        chk("C_awvalid_done", awvalid, 0);
        chk("C_wvalid_hold2", wvalid, 1);
        chk("C_bready_early", bready, 0);
        tick(); wready = 1; look();
        chk("C_wvalid_hold3", wvalid, 1);
        chk("C_wdata", wdata, 32'hAB00_0000);
        tick(); wready = 0; bvalid = 1; look();
        chk("C_wvalid_done", wvalid, 0);
        chk("C_bready", bready, 1);
        chk("C_data_ok", data_sram_data_ok, 1);
        tick(); bvalid = 0; look();
        chk("C_bready_done", bready, 0);
        chk("C_single_ok", data_sram_data_ok, 0);

        // D: data read blocked behind a write, inst read proceeds
        tick(); data_write(32'h8000_0020, 2'd2, 4'hf, 32'h1111_2222); look();
        chk("D_wr_accept", data_sram_addr_ok, 1);
        tick();
        data_sram_wr = 0; data_sram_addr = 32'h8000_0024;
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0080;
        look();
        chk("D_rd_blocked_req", data_sram_addr_ok, 0);
        chk("D_inst_accept", inst_sram_addr_ok, 1);
        tick(); inst_sram_req = 0; arready = 1; awready = 1; wready = 1; look();
        chk("D_rd_blocked_aw", data_sram_addr_ok, 0);
        chk("D_arvalid_inst", 32'({arvalid, arid}), 32'h10);
        chk("D_awvalid", awvalid, 1);
        tick(); arready = 0; awready = 0; wready = 0; rvalid = 1; rid = 0; rdata = 32'h5555_aaaa; look();
        chk("D_inst_data_ok", inst_sram_data_ok, 1);
        chk("D_rd_blocked_b", data_sram_addr_ok, 0);
        chk("D_bready", bready, 1);
        tick(); rvalid = 0; bvalid = 1; look();
        chk("D_wr_data_ok", data_sram_data_ok, 1);
        chk("D_rd_blocked_bhs", data_sram_addr_ok, 0);
        tick(); bvalid = 0; look();
        chk("D_rd_accept_after_b", data_sram_addr_ok, 1);
        tick(); data_sram_req = 0; arready = 1; look();
        chk("D_arid_data", arid, 1);
        chk("D_araddr_data", araddr, 32'h8000_0024);
        tick(); arready = 0; rvalid = 1; rid = 4'h1; rdata = 32'h1111_2222; look();
        chk("D_rd_data_ok", data_sram_data_ok, 1);
        chk("D_rd_rdata", data_sram_rdata, 32'h1111_2222);
        tick(); rvalid = 0; look();

        // E: AW and W together, B late
        tick(); data_write(32'h8000_0030, 2'd1, 4'b1100, 32'hbeef_0000); look();
        chk("E_accept", data_sram_addr_ok, 1);
        tick(); data_sram_req = 0; awready = 1; wready = 1; look();
        chk("E_aw_w_valid", 32'({awvalid, wvalid}), 32'h3);
        chk("E_awsize", awsize, 1);
        for (int i = 0; i < 5; i++) begin
            tick(); awready = 0; wready = 0; look();
            chk("E_bwait_bready", bready, 1);
            chk("E_bwait_no_valid", 32'({awvalid, wvalid}), 32'h0);
            chk("E_bwait_no_ok", data_sram_data_ok, 0);
        end
        tick(); bvalid = 1; look();
        chk("E_data_ok", data_sram_data_ok, 1);
        tick(); bvalid = 0; look();
        chk("E_single_ok", data_sram_data_ok, 0);
        chk("E_bready_done", bready, 0);

        // F: reset while waiting for R
        tick(); inst_sram_req = 1; inst_sram_addr = 32'h1c00_00c0; look();
        chk("F_accept", inst_sram_addr_ok, 1);
        tick(); inst_sram_req = 0; arready = 1; look();
        tick(); arready = 0; look();
        chk("F_in_rwait", rready, 1);
        tick(); resetn = 0; rvalid = 1; rid = 0; rdata = 32'hffff_0000; look();
        chk("F_dropped_ok", inst_sram_data_ok, 0);
        tick(); look();
        chk_quiet("F_reset_quiet");
        tick(); rvalid = 0; resetn = 1; look();
        chk_quiet("F_post_reset");
        tick(); look();
        chk_quiet("F_idle");

        // Randomized run against a word-memory reference model
        for (int i = 0; i < 16; i++) begin
            refmem[i] = $urandom;
            smem[i] = refmem[i];
        end
        rd_out = 0; wr_out = 0; data_rd_out = 0; r_dly = 0; b_dly = 0;
        inst_hold = 0; data_hold = 0; ar_got = 0; aw_got = 0; w_got = 0; b_armed = 0;
        s_araddr = '0; s_awaddr = '0; s_wdata = '0; s_arid = '0; s_wstrb = '0;
        exp_ar_addr = '0; exp_aw_addr = '0; exp_wdata = '0; exp_arid = '0; exp_wstrb = '0;
        exp_arsize = '0; exp_awsize = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            gen = (cyc < 3000);
            if (!gen && iq.size() == 0 && dq.size() == 0 && rd_out == 0 && wr_out == 0) break;
            tick();
            // Requesters
            if (!inst_hold) begin
                inst_sram_req = 0;
                if (gen && $urandom_range(0, 2) == 0) begin
                    inst_sram_req = 1; inst_hold = 1;
                    inst_sram_addr = 32'h1c00_0000 + 32'($urandom_range(0, 63)) * 4;
                end
            end
            if (!data_hold) begin
                data_sram_req = 0;
                if (gen && $urandom_range(0, 2) == 0) begin
                    int sz, off;
                    sz = $urandom_range(0, 2);
                    off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
                    data_sram_req = 1; data_hold = 1;
                    data_sram_wr = 1'($urandom_range(0, 1));
                    data_sram_size = 2'(sz);
                    data_sram_addr = 32'h8000_0000 + 32'($urandom_range(0, 15)) * 4 + 32'(off);
                    data_sram_wstrb = (sz == 0) ? 4'(4'b0001 << off) : (sz == 1) ? 4'(4'b0011 << off) : 4'hf;
                    data_sram_wdata = $urandom;
                end
            end
            // Slave
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready = 1'($urandom_range(0, 1));
            rvalid = 0;
            if (ar_got) begin
                if (r_dly == 0) begin
                    rvalid = 1; rid = s_arid;
                    rdata = s_arid[0] ? smem[s_araddr[5:2]] : ifun(s_araddr);
                end else r_dly--;
            end
            bvalid = 0;
            if (b_armed) begin
                if (b_dly == 0) bvalid = 1;
                else b_dly--;
            end
            look();
            // Expected completion signalling
            e_r_hs = rvalid && rready;
            e_b_hs = bvalid && bready;
            e_inst_ok = e_r_hs && !rid[0];
            e_data_ok = (e_r_hs && rid[0]) || e_b_hs;
            chk("rnd_inst_data_ok", inst_sram_data_ok, e_inst_ok);
            chk("rnd_data_data_ok", data_sram_data_ok, e_data_ok);
            if (e_inst_ok) begin
                chk("rnd_inst_q_nonempty", 32'(iq.size() != 0), 1);
                if (iq.size() != 0) begin
                    popped = iq.pop_front();
                    chk("rnd_inst_rdata", inst_sram_rdata, popped);
                end
            end
            if (e_data_ok) begin
                chk("rnd_data_q_nonempty", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    popped = dq.pop_front();
                    popped_rd = dq_rd.pop_front();
                    if (popped_rd) chk("rnd_data_rdata", data_sram_rdata, popped);
                end
            end
            if (e_r_hs) begin
                ar_got = 0; rd_out--;
                if (rid[0]) data_rd_out--;
            end
            if (e_b_hs) begin
                aw_got = 0; w_got = 0; b_armed = 0; wr_out--;
            end
            // Acceptances
            if (inst_sram_req && inst_sram_addr_ok) begin
                chk("rnd_inst_one_read", 32'(rd_out), 0);
                chk("rnd_inst_vs_data_read", 32'(data_sram_req && !data_sram_wr && data_sram_addr_ok), 0);
                iq.push_back(ifun(inst_sram_addr));
                exp_ar_addr = inst_sram_addr; exp_arid = 4'h0; exp_arsize = 3'd2;
                rd_out++; inst_hold = 0;
            end
            if (data_sram_req && data_sram_addr_ok) begin
                if (data_sram_wr) begin
                    chk("rnd_wr_no_data_rd", 32'(data_rd_out), 0);
                    chk("rnd_wr_one_write", 32'(wr_out), 0);
                    refmem[data_sram_addr[5:2]] = merge(refmem[data_sram_addr[5:2]], data_sram_wdata, data_sram_wstrb);
                    dq.push_back(32'd0); dq_rd.push_back(1'b0);
                    exp_aw_addr = data_sram_addr; exp_awsize = {1'b0, data_sram_size};
                    exp_wstrb = data_sram_wstrb; exp_wdata = data_sram_wdata;
                    wr_out++;
                end else begin
                    chk("rnd_rd_one_read", 32'(rd_out), 0);
                    chk("rnd_rd_no_write", 32'(wr_out), 0);
                    dq.push_back(refmem[data_sram_addr[5:2]]); dq_rd.push_back(1'b1);
                    exp_ar_addr = data_sram_addr; exp_arid = 4'h1; exp_arsize = {1'b0, data_sram_size};
                    rd_out++; data_rd_out++;
                end
                data_hold = 0;
            end
            // AXI request channels
            if (arvalid && arready) begin
                chk("rnd_araddr", araddr, exp_ar_addr);
                chk("rnd_arid_size", 32'({arid, arsize}), 32'({exp_arid, exp_arsize}));
                ar_got = 1; s_araddr = araddr; s_arid = arid; r_dly = $urandom_range(0, 3);
            end
            if (awvalid && awready) begin
                chk("rnd_awaddr", awaddr, exp_aw_addr);
                chk("rnd_awsize", awsize, exp_awsize);
                aw_got = 1; s_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                chk("rnd_wdata", wdata, exp_wdata);
                chk("rnd_wstrb", wstrb, exp_wstrb);
                w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
            end
            if (aw_got && w_got && !b_armed) begin
                smem[s_awaddr[5:2]] = merge(smem[s_awaddr[5:2]], s_wdata, s_wstrb);
                b_armed = 1; b_dly = $urandom_range(0, 4);
            end
        end
        chk("rnd_drain_inst", 32'(iq.size()), 0);
        chk("rnd_drain_data", 32'(dq.size()), 0);
        chk("rnd_drain_outstanding", 32'(rd_out + wr_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
